vga_sync_gen: RTL



---
 rtl/vga_sync_gen_if.sv | 25 ++
 rtl/vga_sync_gen.sv | 90 +++++++++
 2 files changed

// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle between the sync generator and the colour stage / VGA pins.
// master = sync generator, slave = colour stage and pin-side consumer.
interface vga_sync_gen_if;
    logic [7:0] rgb_in;
    logic [9:0] xCoord;
    logic [9:0] yCoord;
    logic       video_on;
    logic       pixel_tick;
    logic       frame_tick;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb_out;

    modport master (
        input  rgb_in,
        output xCoord, yCoord, video_on, pixel_tick, frame_tick,
               hsync, vsync, rgb_out
    );

    modport slave (
        output rgb_in,
        input  xCoord, yCoord, video_on, pixel_tick, frame_tick,
               hsync, vsync, rgb_out
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing front end: pixel-rate divider, h/v counters, registered sync and blanked colour.
// Latency: hsync/vsync/rgb_out lag xCoord/yCoord by one pixel; free-running, no backpressure.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic             pixel_tick;
    logic             h_last;
    logic             v_last;
    logic             video_on;
    logic             hs_active;
    logic             vs_active;
    logic             hsync_q;
    logic             vsync_q;
    logic [7:0]       rgb_q;

    // With CLK_DIV = 1 div never leaves 0, so the tick is permanently high.
    assign pixel_tick = (div == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_count == 10'(H_TOTAL - 1));
    assign v_last     = (v_count == 10'(V_TOTAL - 1));
    assign video_on   = (h_count < 10'(H_VISIBLE)) && (v_count < 10'(V_VISIBLE));
    assign hs_active  = (h_count >= 10'(HS_FIRST)) && (h_count <= 10'(HS_LAST));
    assign vs_active  = (v_count >= 10'(VS_FIRST)) && (v_count <= 10'(VS_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pixel_tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pixel_tick) begin
            h_count <= h_last ? 10'd0 : h_count + 10'd1;
            if (h_last) begin
                v_count <= v_last ? 10'd0 : v_count + 10'd1;
            end
        end
    end

    // Output stage samples the pixel that is ending, giving a one-pixel pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 8'h00;
        end else if (pixel_tick) begin
            hsync_q <= !hs_active;
            vsync_q <= !vs_active;
            rgb_q   <= video_on ? vga.rgb_in : 8'h00;
        end
    end

    assign vga.xCoord     = h_count;
    assign vga.yCoord     = v_count;
    assign vga.video_on   = video_on;
    assign vga.pixel_tick = pixel_tick;
    assign vga.frame_tick = pixel_tick & h_last & v_last;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.rgb_out    = rgb_q;
endmodule
